// File: rtl/rom_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rom_arbiter_pkg
// Shared definitions for the pixel ROM arbiter:
//   VGA_ADDR_W / VGA_DATA_W : default address and word widths (RGB888 words)
//   ROM_LAT_DEF             : default ROM read latency, shared with the rom
//   port_e                  : requester IDs (PORT_DISP = display, PORT_OVL = overlay)
//   tag_t                   : {vld, port} tag carried alongside each ROM read
// ----------------------------------------------------------------------------
package rom_arbiter_pkg;

  localparam int VGA_ADDR_W  = 24;
  localparam int VGA_DATA_W  = 24;
  localparam int ROM_LAT_DEF = 1;

  typedef enum logic {
    PORT_DISP = 1'b0,
    PORT_OVL  = 1'b1
  } port_e;

  typedef struct packed {
    logic  vld;
    port_e port;
  } tag_t;

endpackage

// File: rtl/rom_arb_tag_pipe.sv
// ----------------------------------------------------------------------------
// rom_arb_tag_pipe
// Shift register of read tags. A tag entering with a grant leaves DEPTH
// clocks later, lined up with the matching ROM output word.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous reset, active-high; clears every stage
//   tag_in   in  tag issued in the grant cycle
//   tag_out  out tag at the end of the pipe
// ----------------------------------------------------------------------------
module rom_arb_tag_pipe
  import rom_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/rom_arbiter.sv
// ----------------------------------------------------------------------------
// rom_arbiter
// Shares the single synchronous pixel ROM between the display pixel fetch
// (port 0) and the note/sprite overlay fetch (port 1). Grants are
// combinational, the ROM address is registered, and each returned word is
// steered back to the port that issued it with a one-cycle valid pulse.
// Grant-to-rvalid latency is ROM_LAT+2 clocks; reads return in grant order.
//
// Optional feature (compile-time macro DISPLAY_PRIORITY_EN):
//   defined   : port 0 has strict priority, port 1 only wins when req0=0
//   undefined : round-robin under contention (default)
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   req0/addr0/gnt0             port 0 request, address, same-cycle grant
//   rdata0/rvalid0              port 0 returned word and valid pulse
//   req1/addr1/gnt1             port 1 request, address, same-cycle grant
//   rdata1/rvalid1              port 1 returned word and valid pulse
//   rom_addr                    registered address to the ROM
//   rom_data                    ROM output, valid ROM_LAT clocks after rom_addr
// ----------------------------------------------------------------------------
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W  = VGA_ADDR_W,
  parameter int DATA_W  = VGA_DATA_W,
  parameter int ROM_LAT = ROM_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic [DATA_W-1:0] rdata0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic [DATA_W-1:0] rdata1,
  output logic              rvalid1,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  port_e last_gnt;
  logic  pick1;
  tag_t  tag_p0;
  tag_t  tag_out;

  // Grant decision (stage p0, combinational)
  always_comb begin
`ifdef DISPLAY_PRIORITY_EN
    // last_gnt is still tracked but the display port always wins.
    pick1 = ~req0;
`else
    // Port 1 wins when it requests alone, or on contention when port 0 had
    // the previous grant.
    pick1 = req1 & (~req0 | (last_gnt == PORT_DISP));
`endif
    gnt0 = req0 & ~pick1;
    gnt1 = req1 & pick1;
  end

  always_comb begin
    tag_p0.vld  = gnt0 | gnt1;
    tag_p0.port = gnt1 ? PORT_OVL : PORT_DISP;
  end

  // Address register and round-robin state; rom_addr holds when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= PORT_OVL;
      rom_addr <= '0;
    end else if (gnt0 | gnt1) begin
      last_gnt <= tag_p0.port;
      rom_addr <= gnt1 ? addr1 : addr0;
    end
  end

  // Tag travels ROM_LAT+1 stages: one for the address register, ROM_LAT for the ROM
  rom_arb_tag_pipe #(
    .DEPTH (ROM_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_p0),
    .tag_out (tag_out)
  );

  // Return stage: capture rom_data into the tagged port only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= tag_out.vld & (tag_out.port == PORT_DISP);
      rvalid1 <= tag_out.vld & (tag_out.port == PORT_OVL);
      if (tag_out.vld && tag_out.port == PORT_DISP) rdata0 <= rom_data;
      if (tag_out.vld && tag_out.port == PORT_OVL)  rdata1 <= rom_data;
    end
  end

endmodule
